// File: rtl/veggie_pkg.sv
// veggie_pkg: shared constants, types and helpers for the frame buffer
// write-side engine (frame_drawer) and its raster address generator.
//   SCREEN_W / SCREEN_H : visible frame size in pixels
//   ADDR_W              : frame buffer address width
//   COORD_W             : width of x/y coordinates and extents
package veggie_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;
  localparam int COORD_W  = 10;

  localparam logic [COORD_W-1:0] SCREEN_W_C = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] SCREEN_H_C = COORD_W'(SCREEN_H);
  localparam logic [ADDR_W-1:0]  ROW_STEP   = ADDR_W'(SCREEN_W);

  typedef enum logic [1:0] {
    OP_FILL  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_PLOT  = 2'd2,
    OP_RSVD  = 2'd3
  } draw_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } draw_state_t;

  typedef struct packed {
    draw_op_t           op;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [7:0]         color;
  } draw_cmd_t;

  // y*640 built from two shifts (512 + 128) so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 9) + (yy << 7);
  endfunction

  // Clamp an extent so it does not run past the screen edge.
  // Caller guarantees start < limit.
  function automatic logic [COORD_W-1:0] clip_len(input logic [COORD_W-1:0] start,
                                                  input logic [COORD_W-1:0] len,
                                                  input logic [COORD_W-1:0] limit);
    logic [COORD_W-1:0] avail;
    avail = limit - start;
    return (len < avail) ? len : avail;
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// raster_addr_gen: incremental raster-order address generator.
// Loads a clipped rectangle on start_i and steps one pixel per advance_i,
// left to right within a row, then down to the next row. The address is
// kept incrementally (row base + column), so no multiply is needed.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           load x0_i/w_i/h_i/row_base_i; address = row_base + x0
//   advance_i         step to the next pixel
//   x0_i, w_i, h_i    left column and clipped extent (w,h >= 1)
//   row_base_i        y0 * SCREEN_W
//   addr_o            address of the current pixel
//   last_pixel_o      current pixel is the bottom-right one
//   x_cnt_o, y_cnt_o  column / row offsets inside the rectangle
module raster_addr_gen
  import veggie_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               advance_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  input  logic [ADDR_W-1:0]  row_base_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               last_pixel_o,
  output logic [COORD_W-1:0] x_cnt_o,
  output logic [COORD_W-1:0] y_cnt_o
);

  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] w_q, w_d;
  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
  logic [COORD_W-1:0] y_cnt_q, y_cnt_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               row_end;

  assign row_end = (x_cnt_q == w_q - COORD_W'(1));

  always_comb begin
    x0_d       = x0_q;
    w_d        = w_q;
    h_d        = h_q;
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (start_i) begin
      x0_d       = x0_i;
      w_d        = w_i;
      h_d        = h_i;
      x_cnt_d    = '0;
      y_cnt_d    = '0;
      row_base_d = row_base_i;
      addr_d     = row_base_i + ADDR_W'(x0_i);
    end else if (advance_i) begin
      if (row_end) begin
        x_cnt_d    = '0;
        y_cnt_d    = y_cnt_q + COORD_W'(1);
        row_base_d = row_base_q + ROW_STEP;
        addr_d     = row_base_q + ROW_STEP + ADDR_W'(x0_q);
      end else begin
        x_cnt_d = x_cnt_q + COORD_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      x0_q       <= x0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  assign addr_o       = addr_q;
  assign last_pixel_o = row_end && (y_cnt_q == h_q - COORD_W'(1));
  assign x_cnt_o      = x_cnt_q;
  assign y_cnt_o      = y_cnt_q;

endmodule

// File: rtl/frame_drawer.sv
// frame_drawer: write-side engine for the 640x480 8bpp frame buffer.
// Accepts FILL / CLEAR / PLOT commands over a valid/ready handshake and
// streams one pixel write per clock in raster order.
// Optional build macro FRAME_DRAWER_VBLANK_WAIT_EN: when defined, a
// non-empty command waits in SETUP for a synchronised falling edge of vs_n
// before drawing; otherwise vs_n is ignored.
// Ports:
//   Clk, Reset                    clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_op, cmd_x0, cmd_y0,
//   cmd_w, cmd_h, cmd_color       command fields
//   vs_n                          VGA vertical sync (optional feature only)
//   frame_we, frame_wrAddress,
//   frame_input                   frame buffer write port
//   busy                          command in SETUP or DRAW
//   done                          one-cycle completion pulse
//
// state   | meaning
// IDLE    | ready for a command
// SETUP   | substitute/clip extents, decide empty, compute row base
// DRAW    | one pixel write per clock
// DONE    | completion pulse, back to IDLE
module frame_drawer
  import veggie_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [7:0]         cmd_color,
  input  logic               vs_n,
  output logic               frame_we,
  output logic [ADDR_W-1:0]  frame_wrAddress,
  output logic [7:0]         frame_input,
  output logic               busy,
  output logic               done
);

  draw_state_t state_q, state_d;
  draw_cmd_t   cmd_q, cmd_d;
  logic        frame_we_q, frame_we_d;

  logic [COORD_W-1:0] set_x0, set_y0, set_w, set_h;
  logic               set_empty;
  logic [ADDR_W-1:0]  set_row_base;
  logic               draw_go;
  logic               gen_start, gen_advance, gen_last;
  logic [COORD_W-1:0] unused_x_cnt, unused_y_cnt;

  // Resolve the effective rectangle from the latched command.
  always_comb begin
    set_x0    = cmd_q.x0;
    set_y0    = cmd_q.y0;
    set_w     = cmd_q.w;
    set_h     = cmd_q.h;
    set_empty = 1'b0;
    case (cmd_q.op)
      OP_CLEAR: begin
        set_x0 = '0;
        set_y0 = '0;
        set_w  = SCREEN_W_C;
        set_h  = SCREEN_H_C;
      end
      OP_PLOT: begin
        set_w = COORD_W'(1);
        set_h = COORD_W'(1);
      end
      OP_FILL: ;
      default: set_empty = 1'b1;
    endcase
    if (set_x0 >= SCREEN_W_C || set_y0 >= SCREEN_H_C) begin
      set_empty = 1'b1;
    end else begin
      set_w = clip_len(set_x0, set_w, SCREEN_W_C);
      set_h = clip_len(set_y0, set_h, SCREEN_H_C);
      if (set_w == '0 || set_h == '0) set_empty = 1'b1;
    end
  end

  assign set_row_base = row_base_of(set_y0);

`ifdef FRAME_DRAWER_VBLANK_WAIT_EN
  // [0],[1]: synchroniser, [2]: previous synchronised value for edge detect.
  // Reset high so an idle-high vs_n does not look like a fall after reset.
  logic [2:0] vs_sync_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vs_sync_q <= 3'b111;
    else       vs_sync_q <= {vs_sync_q[1:0], vs_n};
  end

  assign draw_go = vs_sync_q[2] & ~vs_sync_q[1];
`else
  logic unused_vs_n;
  assign unused_vs_n = vs_n;
  assign draw_go     = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    gen_start   = 1'b0;
    gen_advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d.op    = draw_op_t'(cmd_op);
          cmd_d.x0    = cmd_x0;
          cmd_d.y0    = cmd_y0;
          cmd_d.w     = cmd_w;
          cmd_d.h     = cmd_h;
          cmd_d.color = cmd_color;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        // Empty commands finish straight away, even when waiting for vblank.
        if (set_empty) begin
          state_d = S_DONE;
        end else if (draw_go) begin
          gen_start = 1'b1;
          state_d   = S_DRAW;
        end
      end
      S_DRAW: begin
        gen_advance = 1'b1;
        if (gen_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    frame_we_d = (state_d == S_DRAW);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      frame_we_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      frame_we_q <= frame_we_d;
    end
  end

  raster_addr_gen u_addr_gen (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .start_i      (gen_start),
    .advance_i    (gen_advance),
    .x0_i         (set_x0),
    .w_i          (set_w),
    .h_i          (set_h),
    .row_base_i   (set_row_base),
    .addr_o       (frame_wrAddress),
    .last_pixel_o (gen_last),
    .x_cnt_o      (unused_x_cnt),
    .y_cnt_o      (unused_y_cnt)
  );

  assign frame_we    = frame_we_q;
  assign frame_input = cmd_q.color;
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q == S_SETUP) || (state_q == S_DRAW);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_drawer.sv
module tb_frame_drawer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [7:0]  cmd_color;
  logic        vs_n;
  logic        frame_we;
  logic [18:0] frame_wrAddress;
  logic [7:0]  frame_input;
  logic        busy;
  logic        done;

  frame_drawer dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_x0          (cmd_x0),
    .cmd_y0          (cmd_y0),
    .cmd_w           (cmd_w),
    .cmd_h           (cmd_h),
    .cmd_color       (cmd_color),
    .vs_n            (vs_n),
    .frame_we        (frame_we),
    .frame_wrAddress (frame_wrAddress),
    .frame_input     (frame_input),
    .busy            (busy),
    .done            (done)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents a command at the current sample point and returns just after
  // the acceptance edge (cycle 1 after acceptance).
  task automatic issue(input logic [1:0] op, input int x0, input int y0,
                       input int w, input int h, input logic [7:0] color);
    cmd_op    = op;
    cmd_x0    = 10'(x0);
    cmd_y0    = 10'(y0);
    cmd_w     = 10'(w);
    cmd_h     = 10'(h);
    cmd_color = color;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    int         x0, y0, w, h;
    logic [7:0] color;
    int         n, first, last;
  } vec_t;

  vec_t vecs[12];

  initial begin
    Reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x0 = '0; cmd_y0 = '0;
    cmd_w = '0; cmd_h = '0; cmd_color = '0; vs_n = 1'b1;

    // name,        op, x0,  y0,  w,    h,    color, n,    first,  last
    vecs[0]  = '{"plot_3_2",     2'd2, 3,   2,   0,    0,    8'hE0, 1,    1283,   1283};
    vecs[1]  = '{"fill_clip_br", 2'd0, 638, 478, 5,    3,    8'h55, 4,    306558, 307199};
    vecs[2]  = '{"fill_x700",    2'd0, 700, 0,   5,    5,    8'h11, 0,    0,      0};
    vecs[3]  = '{"fill_w0",      2'd0, 10,  10,  0,    5,    8'h22, 0,    0,      0};
    vecs[4]  = '{"fill_h0",      2'd0, 0,   0,   5,    0,    8'h33, 0,    0,      0};
    vecs[5]  = '{"op_rsvd",      2'd3, 1,   1,   4,    4,    8'h44, 0,    0,      0};
    vecs[6]  = '{"plot_x640",    2'd2, 640, 0,   0,    0,    8'h66, 0,    0,      0};
    vecs[7]  = '{"fill_bottom",  2'd0, 0,   470, 640,  10,   8'h1C, 6400, 300800, 307199};
    vecs[8]  = '{"fill_3x4",     2'd0, 100, 200, 3,    4,    8'hAB, 12,   128100, 130022};
    vecs[9]  = '{"plot_corner",  2'd2, 639, 479, 9,    9,    8'hFF, 1,    307199, 307199};
    vecs[10] = '{"fill_clip_lr", 2'd0, 5,   479, 1000, 1000, 8'h0F, 635,  306565, 307199};
    vecs[11] = '{"plot_y480",    2'd2, 0,   480, 0,    0,    8'h77, 0,    0,      0};

    // Reset values, sampled mid-cycle while Reset is held.
    #23;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(frame_we), 0);
    check("rst_addr", int'(frame_wrAddress), 0);
    check("rst_data", int'(frame_input), 0);
    tick();
    Reset = 1'b0;
    tick();

`ifdef FRAME_DRAWER_VBLANK_WAIT_EN
    begin
      int nw;
      nw = 0;
      issue(2'd2, 3, 2, 0, 0, 8'hE0);
      for (int c = 0; c < 6; c++) begin
        if (frame_we) nw++;
        tick();
      end
      check("vb_no_write_before_fall", nw, 0);
      check("vb_busy_waiting", int'(busy), 1);
      vs_n = 1'b0;
      tick();
      check("vb_we_fall_plus1", int'(frame_we), 0);
      tick();
      check("vb_we_fall_plus2", int'(frame_we), 0);
      tick();
      check("vb_we_fall_plus3", int'(frame_we), 1);
      check("vb_addr", int'(frame_wrAddress), 1283);
      tick();
      check("vb_done", int'(done), 1);
      vs_n = 1'b1;
      tick();
    end
`else
    // Table-driven commands.
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      int ex0, ey0, ew, eh, nw, first, last, seq_err, data_err, gap_err, done_cyc, exp_addr;
      v = vecs[i];
      ex0 = v.x0; ey0 = v.y0; ew = v.w; eh = v.h;
      if (v.op == 2'd1) begin ex0 = 0; ey0 = 0; ew = 640; eh = 480; end
      else if (v.op == 2'd2) begin ew = 1; eh = 1; end
      if (ew > 640 - ex0) ew = 640 - ex0;
      if (eh > 480 - ey0) eh = 480 - ey0;
      nw = 0; first = -1; last = -1; seq_err = 0; data_err = 0; gap_err = 0; done_cyc = -1;
      check({v.name, "_ready"}, int'(cmd_ready), 1);
      issue(v.op, v.x0, v.y0, v.w, v.h, v.color);
      for (int cyc = 1; cyc < 20000; cyc++) begin
        if (frame_we) begin
          if (ew > 0) exp_addr = (ey0 + nw / ew) * 640 + ex0 + nw % ew;
          else        exp_addr = -1;
          if (int'(frame_wrAddress) != exp_addr) seq_err++;
          if (frame_input != v.color) data_err++;
          if (cyc != 2 + nw) gap_err++;
          if (nw == 0) first = int'(frame_wrAddress);
          last = int'(frame_wrAddress);
          nw++;
        end
        if (done) begin
          done_cyc = cyc;
          break;
        end
        tick();
      end
      check({v.name, "_writes"}, nw, v.n);
      check({v.name, "_done_cycle"}, done_cyc, v.n + 2);
      check({v.name, "_addr_seq_errs"}, seq_err, 0);
      check({v.name, "_data_errs"}, data_err, 0);
      check({v.name, "_gap_errs"}, gap_err, 0);
      if (v.n > 0) begin
        check({v.name, "_first_addr"}, first, v.first);
        check({v.name, "_last_addr"}, last, v.last);
      end
      tick();
    end

    // A second command held during a draw is only taken 1 cycle after done.
    begin
      int nw, done_cyc, acc_cyc, w2_cyc, w2_addr, w2_data, busy_seen;
      nw = 0; done_cyc = -1; acc_cyc = -1; w2_cyc = -1; w2_addr = -1; w2_data = -1; busy_seen = 0;
      issue(2'd0, 0, 0, 20, 2, 8'h33);
      for (int cyc = 1; cyc < 200; cyc++) begin
        if (cyc == 5) begin
          cmd_op = 2'd2; cmd_x0 = 10'd7; cmd_y0 = 10'd7; cmd_color = 8'h99; cmd_valid = 1'b1;
          busy_seen = int'(busy);
        end
        if (acc_cyc >= 0 && cyc == acc_cyc + 1) cmd_valid = 1'b0;
        if (frame_we) begin
          if (acc_cyc < 0) nw++;
          else begin
            w2_cyc = cyc; w2_addr = int'(frame_wrAddress); w2_data = int'(frame_input);
            break;
          end
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (cmd_valid && cmd_ready && acc_cyc < 0) acc_cyc = cyc;
        tick();
      end
      check("hold_busy_during_draw", busy_seen, 1);
      check("hold_first_writes", nw, 40);
      check("hold_first_done_cycle", done_cyc, 42);
      check("hold_accept_cycle", acc_cyc, 43);
      check("hold_second_write_cycle", w2_cyc, 45);
      check("hold_second_addr", w2_addr, 4487);
      check("hold_second_data", w2_data, 8'h99);
      cmd_valid = 1'b0;
      for (int c = 0; c < 10 && !cmd_ready; c++) tick();
      check("hold_back_idle", int'(cmd_ready), 1);
    end

    // Asynchronous reset in the middle of a CLEAR.
    begin
      int nw, seq_err, data_err, post_writes;
      nw = 0; seq_err = 0; data_err = 0; post_writes = 0;
      issue(2'd1, 9, 9, 9, 9, 8'h1C);
      for (int cyc = 1; cyc < 2000; cyc++) begin
        if (frame_we) begin
          if (int'(frame_wrAddress) != nw) seq_err++;
          if (frame_input != 8'h1C) data_err++;
          nw++;
          if (nw == 1001) break;
        end
        tick();
      end
      check("clr_writes_before_reset", nw, 1001);
      check("clr_addr_seq_errs", seq_err, 0);
      check("clr_data_errs", data_err, 0);
      #3;
      Reset = 1'b1;
      #1;
      check("arst_we_dropped", int'(frame_we), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_ready", int'(cmd_ready), 1);
      check("arst_addr", int'(frame_wrAddress), 0);
      tick();
      Reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (frame_we) post_writes++;
      end
      check("arst_no_writes_after", post_writes, 0);
      check("arst_idle_ready", int'(cmd_ready), 1);
      issue(2'd2, 1, 1, 0, 0, 8'h5A);
      tick();
      check("arst_plot_we", int'(frame_we), 1);
      check("arst_plot_addr", int'(frame_wrAddress), 641);
      tick();
      check("arst_plot_done", int'(done), 1);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
